wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 25 ++
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: one Wishbone link (classic cycle signals).
// The master modport drives the request, the slave modport drives the response.
interface wb_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_o;
    logic [DATA_W-1:0] dat_i;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, dat_o,
        input  dat_i, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_o,
        output dat_i, ack, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter (m0 = RBCP bridge, m1 = local
// sequencer) sharing one slave bus. Round-robin on simultaneous requests,
// one IDLE cycle between grants. Defining WB_ARB_TIMEOUT_EN builds a stall
// timeout that errors the granted master and sets a sticky to_flag.
module wb_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int TO_CYCLES = 255
) (
    input  logic         CLK,
    input  logic         RST,
    wb_arbiter_if.slave  m0,
    wb_arbiter_if.slave  m1,
    wb_arbiter_if.master s,
    output logic [1:0]   gnt,
    output logic         to_flag
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_G0   = 2'b01;
    localparam logic [1:0] ST_G1   = 2'b10;

    if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_to_cycles
        $error("wb_arbiter: TO_CYCLES must lie in 1..65535");
    end

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;   // 1: master 1 was granted most recently
    logic              g0, g1;
    logic              to_hit;
    logic [ADDR_W-1:0] adr_mux;
    logic [DATA_W-1:0] wdat_mux;

    // Grant decode from the registered state; reset masks all outputs at once
    always_comb begin
        g0  = (state_q == ST_G0) && !RST;
        g1  = (state_q == ST_G1) && !RST;
        gnt = {g1, g0};
    end

    // Next grant: round-robin from IDLE, hold until the owner drops cyc
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc && (!m1.cyc || last_q)) begin
                    state_d = ST_G0;
                    last_d  = 1'b0;
                end else if (m1.cyc) begin
                    state_d = ST_G1;
                    last_d  = 1'b1;
                end
            end
            ST_G0:   if (!m0.cyc) state_d = ST_IDLE;
            ST_G1:   if (!m1.cyc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant state and round-robin history
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Forward the granted master to the slave and route the response back
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        adr_mux  = '0;
        wdat_mux = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_i = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_i = '0;
        if (g0) begin
            s.cyc    = m0.cyc;
            s.stb    = m0.stb;
            s.we     = m0.we;
            adr_mux  = m0.adr;
            wdat_mux = m0.dat_o;
            m0.ack   = s.ack;
            m0.err   = s.err | to_hit;
            m0.dat_i = s.dat_i;
        end else if (g1) begin
            s.cyc    = m1.cyc;
            s.stb    = m1.stb;
            s.we     = m1.we;
            adr_mux  = m1.adr;
            wdat_mux = m1.dat_o;
            m1.ack   = s.ack;
            m1.err   = s.err | to_hit;
            m1.dat_i = s.dat_i;
        end
    end

    assign s.adr   = adr_mux;
    assign s.dat_o = wdat_mux;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_flag_q, to_flag_d;
    logic        stall;

    // A stall cycle is a granted strobe with no slave response; the error
    // fires on the stall cycle that would bring the count to TO_CYCLES
    always_comb begin
        stall  = ((g0 && m0.stb) || (g1 && m1.stb)) && !s.ack && !s.err;
        to_hit = stall && (to_cnt_q == TO_LAST);
    end

    // Counter runs only across uninterrupted stalls within one grant
    always_comb begin
        to_cnt_d  = '0;
        to_flag_d = to_flag_q | to_hit;
        if (stall && (state_d == state_q) && !to_hit) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    // Timeout counter and sticky flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign to_flag = to_flag_q && !RST;
`else
    assign to_hit  = 1'b0;
    assign to_flag = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the arbitration rules.
module tb_wb_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] gnt;
    logic       to_flag;

    int errors = 0;
    int checks = 0;

    // model: own 0 = nobody, 1 = master 0, 2 = master 1; last_m = last granted master
    int own    = 0;
    int last_m = 1;
    int cnt    = 0;
    bit toflag = 1'b0;

    wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
    wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

    wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TO)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .gnt     (gnt),
        .to_flag (to_flag)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_m0(input logic c, input logic st, input logic w, input logic [15:0] a, input logic [7:0] d);
        m0_bus.cyc = c; m0_bus.stb = st; m0_bus.we = w; m0_bus.adr = a; m0_bus.dat_o = d;
    endtask

    task automatic set_m1(input logic c, input logic st, input logic w, input logic [15:0] a, input logic [7:0] d);
        m1_bus.cyc = c; m1_bus.stb = st; m1_bus.we = w; m1_bus.adr = a; m1_bus.dat_o = d;
    endtask

    task automatic set_slv(input logic a, input logic e, input logic [7:0] d);
        s_bus.ack = a; s_bus.err = e; s_bus.dat_i = d;
    endtask

    function automatic logic owner_stb();
        if (own == 1) return m0_bus.stb;
        if (own == 2) return m1_bus.stb;
        return 1'b0;
    endfunction

    function automatic logic model_hit();
`ifdef WB_ARB_TIMEOUT_EN
        return (own != 0) && owner_stb() && !s_bus.ack && !s_bus.err && (cnt == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [49:0] obs_vec();
        return {gnt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_o,
                m0_bus.ack, m0_bus.err, m0_bus.dat_i,
                m1_bus.ack, m1_bus.err, m1_bus.dat_i, to_flag};
    endfunction

    function automatic logic [49:0] exp_vec();
        logic [1:0]  g;
        logic [26:0] sb;
        logic [9:0]  r0, r1;
        logic        hit;
        g = '0; sb = '0; r0 = '0; r1 = '0;
        if (RST) return '0;
        hit = model_hit();
        if (own == 1) begin
            g  = 2'b01;
            sb = {m0_bus.cyc, m0_bus.stb, m0_bus.we, m0_bus.adr, m0_bus.dat_o};
            r0 = {s_bus.ack, s_bus.err | hit, s_bus.dat_i};
        end else if (own == 2) begin
            g  = 2'b10;
            sb = {m1_bus.cyc, m1_bus.stb, m1_bus.we, m1_bus.adr, m1_bus.dat_o};
            r1 = {s_bus.ack, s_bus.err | hit, s_bus.dat_i};
        end
        return {g, sb, r0, r1, toflag};
    endfunction

    task automatic model_clock();
        int  nxt;
        logic hit;
        if (RST) begin
            own = 0; last_m = 1; cnt = 0; toflag = 1'b0;
            return;
        end
        hit = model_hit();
        nxt = own;
        if (own == 0) begin
            if (m0_bus.cyc && (!m1_bus.cyc || last_m == 1)) nxt = 1;
            else if (m1_bus.cyc && (!m0_bus.cyc || last_m == 0)) nxt = 2;
        end else if (own == 1 && !m0_bus.cyc) begin
            nxt = 0;
        end else if (own == 2 && !m1_bus.cyc) begin
            nxt = 0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (hit) toflag = 1'b1;
        if (own != 0 && nxt == own && owner_stb() && !s_bus.ack && !s_bus.err && !hit) cnt = cnt + 1;
        else cnt = 0;
`endif
        if (own == 0 && nxt != 0) last_m = nxt - 1;
        own = nxt;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_m0(0, 0, 0, 16'h0, 8'h0);
        set_m1(0, 0, 0, 16'h0, 8'h0);
        set_slv(0, 0, 8'h0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        set_m0(1, 1, 1, 16'h1234, 8'h56);
        set_m1(1, 1, 0, 16'h4321, 8'h65);
        set_slv(1, 1, 8'hFF);
        RST = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== 50'h0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got=%h want=0", k, obs_vec());
            end
            tick();
        end
        RST = 1'b0;
        set_m0(1, 0, 0, 16'h0, 8'h0);
        set_m1(0, 0, 0, 16'h0, 8'h0);
        set_slv(0, 0, 8'h0);
        @(negedge CLK);
        checks++;
        if (obs_vec() !== 50'h0) begin
            errors++;
            $display("FAIL post_reset_idle got=%h want=0", obs_vec());
        end
        tick();
        @(negedge CLK);
        checks++;
        if (gnt !== 2'b01 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL grant_latency got=%h want=%h", obs_vec(), exp_vec());
        end
        set_m0(0, 0, 0, 16'h0, 8'h0);
        tick();
        tick();
    endtask

    task automatic test_single_write();
        int acks0 = 0;
        set_m0(1, 1, 1, 16'h0012, 8'hA5);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL write_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            acks0 += int'(m0_bus.ack);
            checks++;
            if (m1_bus.ack !== 1'b0) begin
                errors++;
                $display("FAIL write_m1_ack k=%0d got=%b want=0", k, m1_bus.ack);
            end
            if (k == 0) begin
                checks++;
                if (gnt !== 2'b00) begin errors++; $display("FAIL write_idle got=%b want=00", gnt); end
            end
            if (k == 1) begin
                checks++;
                if ({gnt, s_bus.we, s_bus.adr, s_bus.dat_o} !== {2'b01, 1'b1, 16'h0012, 8'hA5}) begin
                    errors++;
                    $display("FAIL write_fwd got=%b/%h/%h want=01/0012/a5", gnt, s_bus.adr, s_bus.dat_o);
                end
            end
            if (k == 2) begin
                checks++;
                if (m0_bus.ack !== 1'b1) begin errors++; $display("FAIL write_ack got=%b want=1", m0_bus.ack); end
            end
            tick();
            if (k == 1) set_slv(1, 0, 8'h00);
            if (k == 2) begin set_slv(0, 0, 8'h00); set_m0(0, 0, 0, 16'h0, 8'h0); end
        end
        checks++;
        if (acks0 != 1) begin errors++; $display("FAIL write_ack_pulses got=%0d want=1", acks0); end
    endtask

    task automatic test_contention();
        do_reset();
        set_m0(1, 1, 1, 16'h0040, 8'h5A);
        set_m1(1, 1, 0, 16'h0080, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL contend_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            if (k == 1 || k == 4) begin
                checks++;
                if (gnt !== 2'b01) begin errors++; $display("FAIL contend_first k=%0d got=%b want=01", k, gnt); end
            end
            if (k == 5) begin
                checks++;
                if (gnt !== 2'b00) begin errors++; $display("FAIL contend_gap got=%b want=00", gnt); end
            end
            if (k == 6) begin
                checks++;
                if ({gnt, s_bus.adr} !== {2'b10, 16'h0080}) begin
                    errors++;
                    $display("FAIL contend_second got=%b/%h want=10/0080", gnt, s_bus.adr);
                end
            end
            tick();
            if (k == 3) set_m0(0, 0, 0, 16'h0, 8'h0);
            if (k == 6) set_m1(0, 0, 0, 16'h0, 8'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd [3];
        rd[0] = 8'h11; rd[1] = 8'h22; rd[2] = 8'h33;
        do_reset();
        set_m1(1, 1, 0, 16'h0100, 8'h00);
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            if (k <= 6) begin
                checks++;
                if ({gnt[0], m0_bus.ack, m0_bus.dat_i} !== 10'h0) begin
                    errors++;
                    $display("FAIL b2b_m0_stalled k=%0d got=%b/%b/%h want=0/0/00", k, gnt[0], m0_bus.ack, m0_bus.dat_i);
                end
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if ({m1_bus.ack, m1_bus.dat_i, s_bus.adr} !== {1'b1, rd[k-2], 16'h0100 + 16'(k-2)}) begin
                    errors++;
                    $display("FAIL b2b_read k=%0d got=%b/%h/%h want=1/%h/%h", k, m1_bus.ack, m1_bus.dat_i,
                             s_bus.adr, rd[k-2], 16'h0100 + 16'(k-2));
                end
            end
            if (k == 7) begin
                checks++;
                if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_m0_after got=%b want=01", gnt); end
            end
            tick();
            case (k)
                0: set_m0(1, 1, 1, 16'h0200, 8'h77);
                1: set_slv(1, 0, 8'h11);
                2: begin set_m1(1, 1, 0, 16'h0101, 8'h00); set_slv(1, 0, 8'h22); end
                3: begin set_m1(1, 1, 0, 16'h0102, 8'h00); set_slv(1, 0, 8'h33); end
                4: begin set_m1(0, 0, 0, 16'h0, 8'h0); set_slv(0, 0, 8'h00); end
                7: set_m0(0, 0, 0, 16'h0, 8'h0);
                default: ;
            endcase
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_m0(1, 1, 0, 16'h0300, 8'h00);
        for (int k = 0; k < 14; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
`ifdef WB_ARB_TIMEOUT_EN
            if (k >= 1 && k <= 9) begin
                checks++;
                if (m0_bus.err !== (k == 8)) begin
                    errors++;
                    $display("FAIL timeout_err k=%0d got=%b want=%b", k, m0_bus.err, (k == 8));
                end
            end
            if (k == 8 || k == 9 || k == 12 || k == 13) begin
                checks++;
                if (to_flag !== (k != 8)) begin
                    errors++;
                    $display("FAIL timeout_flag k=%0d got=%b want=%b", k, to_flag, (k != 8));
                end
            end
`else
            checks++;
            if ({m0_bus.err, to_flag} !== 2'b00) begin
                errors++;
                $display("FAIL no_timeout k=%0d got=%b/%b want=0/0", k, m0_bus.err, to_flag);
            end
`endif
            tick();
            case (k)
                9:  set_m0(0, 0, 0, 16'h0, 8'h0);
                10: begin set_m1(1, 1, 1, 16'h0001, 8'h42); set_slv(1, 0, 8'h00); end
                12: begin set_m1(0, 0, 0, 16'h0, 8'h0); set_slv(0, 0, 8'h00); end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m1(1, 1, 0, 16'h0010, 8'h00);
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            if (k == 1) begin
                checks++;
                if (gnt !== 2'b10) begin errors++; $display("FAIL rstmid_g1 got=%b want=10", gnt); end
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (obs_vec() !== 50'h0) begin
                    errors++;
                    $display("FAIL rstmid_quiet k=%0d got=%h want=0", k, obs_vec());
                end
            end
            if (k == 4) begin
                checks++;
                if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_m0_first got=%b want=01", gnt); end
            end
            tick();
            case (k)
                1: begin RST = 1'b1; set_slv(1, 0, 8'h99); end
                2: begin RST = 1'b0; set_m0(1, 1, 0, 16'h0020, 8'h00); end
                4: begin set_m0(0, 0, 0, 16'h0, 8'h0); set_m1(0, 0, 0, 16'h0, 8'h0); set_slv(0, 0, 8'h00); end
                default: ;
            endcase
        end
    endtask

    task automatic test_random();
        logic c0 = 1'b0;
        logic c1 = 1'b0;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            tick();
            if ($urandom_range(7) == 0) c0 = ~c0;
            if ($urandom_range(7) == 0) c1 = ~c1;
            set_m0(c0, c0 & 1'($urandom_range(4) != 0), 1'($urandom_range(1)), 16'($urandom), 8'($urandom));
            set_m1(c1, c1 & 1'($urandom_range(4) != 0), 1'($urandom_range(1)), 16'($urandom), 8'($urandom));
            set_slv(1'($urandom_range(5) == 0), 1'($urandom_range(23) == 0), 8'($urandom));
            RST = 1'($urandom_range(99) == 0);
        end
        RST = 1'b0;
    endtask

    initial begin
        set_m0(0, 0, 0, 16'h0, 8'h0);
        set_m1(0, 0, 0, 16'h0, 8'h0);
        set_slv(0, 0, 8'h0);
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
